ov7670_frame_reader: RTL and testbench

- Read-side responder to the capture sequencer's READ_EN / RD_FRAME handshake.
- When READ_EN is granted, it fetches one stored frame of H_ACT x V_ACT pixels from the frame buffer through a fixed-latency read port and streams the pixels out over a valid/ready interface with SOF/EOL markers.
- On delivery of the last pixel it pulses RD_FRAME, and the sequencer returns to capture.

---
 rtl/ov7670_pkg.sv | 15 +
 rtl/ov7670_pix_fifo.sv | 53 +++++
 rtl/ov7670_frame_reader.sv | 143 ++++++++++++++
 tb/tb_ov7670_frame_reader.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ov7670_pkg.sv
// Shared OV7670 types: reader FSM encoding and frame geometry.
package ov7670_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } rd_state_e;

  localparam int H_ACT_DEF = 320;
  localparam int V_ACT_DEF = 240;
  localparam int PIX_W     = 16;

endpackage

// File: rtl/ov7670_pix_fifo.sv
// First-word-fall-through pixel FIFO with occupancy count and sync flush.
module ov7670_pix_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 16
) (
  input  logic                       SYS_CLK,
  input  logic                       RST_N,
  input  logic                       flush,
  input  logic                       push,
  input  logic [W-1:0]               wdata,
  input  logic                       pop,
  output logic [W-1:0]               rdata,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [CW-1:0] cnt;
  logic          full, do_push, do_pop;

  assign empty   = cnt == '0;
  assign full    = cnt == CW'(DEPTH);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rptr];
  assign count   = cnt;

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      if (do_push && !do_pop)      cnt <= cnt + CW'(1);
      else if (do_pop && !do_push) cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (do_push && !flush) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/ov7670_frame_reader.sv
// Streams one stored frame from the frame buffer on each READ_EN grant.
module ov7670_frame_reader
  import ov7670_pkg::*;
#(
  parameter int H_ACT      = H_ACT_DEF,
  parameter int V_ACT      = V_ACT_DEF,
  parameter int DATA_W     = PIX_W,
  parameter int ADDR_W     = 17,
  parameter int BASE_ADDR  = 0,
  parameter int RD_LAT     = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              SYS_CLK,
  input  logic              RST_N,
  input  logic              READ_EN,
  output logic              RD_FRAME,
  output logic              BUSY,
  output logic              MEM_RD,
  output logic [ADDR_W-1:0] MEM_ADDR,
  input  logic [DATA_W-1:0] MEM_RDATA,
  output logic [DATA_W-1:0] PIX_DATA,
  output logic              PIX_VALID,
  input  logic              PIX_READY,
  output logic              PIX_SOF,
  output logic              PIX_EOL
);

  localparam int TOTAL = H_ACT * V_ACT;
  localparam int IW    = $clog2(TOTAL + 1);
  localparam int XW    = $clog2(H_ACT + 1);
  localparam int YW    = $clog2(V_ACT + 1);
  localparam int CW    = $clog2(FIFO_DEPTH + 1);

  rd_state_e         state_q, state_d;
  logic [IW-1:0]     rd_idx_q;
  logic [XW-1:0]     out_x_q;
  logic [YW-1:0]     out_y_q;
  logic              armed_q;
  logic [RD_LAT-1:0] infl_q;
  logic [ADDR_W-1:0] addr_q, addr_cur;
  logic [CW-1:0]     fifo_cnt;
  logic [DATA_W-1:0] fifo_head;
  logic              fifo_empty;
  logic              busy_st, start, abort, issue, push, pop;
  logic              x_last, y_last;
  int                infl_n;

  always_comb begin
    infl_n = 0;
    for (int i = 0; i < RD_LAT; i++) infl_n += int'(infl_q[i]);
  end

  assign busy_st  = state_q == FETCH || state_q == DRAIN;
  assign abort    = busy_st && !READ_EN;
  assign start    = state_q == IDLE && READ_EN && armed_q;
  // Credits count words already in flight so the FIFO can never overflow.
  assign issue    = state_q == FETCH && READ_EN
                 && int'(rd_idx_q) < TOTAL
                 && int'(fifo_cnt) + infl_n < FIFO_DEPTH;
  assign push     = infl_q[RD_LAT-1] && !abort;
  assign addr_cur = ADDR_W'(BASE_ADDR) + ADDR_W'(rd_idx_q);

  assign x_last    = out_x_q == XW'(H_ACT - 1);
  assign y_last    = out_y_q == YW'(V_ACT - 1);
  assign PIX_VALID = !fifo_empty;
  assign PIX_DATA  = fifo_empty ? '0 : fifo_head;
  assign pop       = PIX_VALID && PIX_READY;
  assign PIX_SOF   = PIX_VALID && out_x_q == '0 && out_y_q == '0;
  assign PIX_EOL   = PIX_VALID && x_last;

  assign MEM_RD   = issue;
  assign MEM_ADDR = issue ? addr_cur : addr_q;
  assign RD_FRAME = state_q == DONE;
  assign BUSY     = busy_st;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start) state_d = FETCH;
      FETCH: begin
        if (abort) state_d = IDLE;
        else if (issue && rd_idx_q == IW'(TOTAL - 1)) state_d = DRAIN;
      end
      DRAIN: begin
        if (abort) state_d = IDLE;
        else if (pop && x_last && y_last) state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      rd_idx_q <= '0;
      out_x_q  <= '0;
      out_y_q  <= '0;
      armed_q  <= 1'b1;
      infl_q   <= '0;
      addr_q   <= '0;
    end else begin
      state_q <= state_d;
      if (!READ_EN)   armed_q <= 1'b1;
      else if (start) armed_q <= 1'b0;
      if (abort) infl_q <= '0;
      else       infl_q <= (infl_q << 1) | RD_LAT'(issue);
      if (start) begin
        rd_idx_q <= '0;
      end else if (issue) begin
        rd_idx_q <= rd_idx_q + IW'(1);
        addr_q   <= addr_cur;
      end
      if (start) begin
        out_x_q <= '0;
        out_y_q <= '0;
      end else if (pop) begin
        if (x_last) begin
          out_x_q <= '0;
          out_y_q <= out_y_q + YW'(1);
        end else begin
          out_x_q <= out_x_q + XW'(1);
        end
      end
    end
  end

  ov7670_pix_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (DATA_W)
  ) u_fifo (
    .SYS_CLK (SYS_CLK),
    .RST_N   (RST_N),
    .flush   (abort),
    .push    (push),
    .wdata   (MEM_RDATA),
    .pop     (pop),
    .rdata   (fifo_head),
    .empty   (fifo_empty),
    .count   (fifo_cnt)
  );

endmodule

// File: tb/tb_ov7670_frame_reader.sv
// Scoreboard bench for ov7670_frame_reader on a 4x3 frame.
module tb_ov7670_frame_reader;

  typedef struct {
    logic [15:0] data;
    logic        sof;
    logic        eol;
    logic        last;
    int          idx;
  } exp_t;

  logic clk = 1'b0;
  logic RST_N = 1'b0;
  always #5 clk = ~clk;

  logic        READ_EN = 1'b0, PIX_READY = 1'b1;
  logic        RD_FRAME, BUSY, MEM_RD, PIX_VALID, PIX_SOF, PIX_EOL;
  logic [16:0] MEM_ADDR;
  logic [15:0] MEM_RDATA, PIX_DATA;

  logic        READ_EN1 = 1'b0, PIX_READY1 = 1'b1;
  logic        RD_FRAME1, BUSY1, MEM_RD1, PIX_VALID1, PIX_SOF1, PIX_EOL1;
  logic [16:0] MEM_ADDR1;
  logic [15:0] MEM_RDATA1, PIX_DATA1;

  ov7670_frame_reader #(
    .H_ACT(4), .V_ACT(3), .DATA_W(16), .ADDR_W(17),
    .BASE_ADDR(0), .RD_LAT(2), .FIFO_DEPTH(4)
  ) u_dut (
    .SYS_CLK(clk), .RST_N(RST_N), .READ_EN(READ_EN),
    .RD_FRAME(RD_FRAME), .BUSY(BUSY), .MEM_RD(MEM_RD),
    .MEM_ADDR(MEM_ADDR), .MEM_RDATA(MEM_RDATA),
    .PIX_DATA(PIX_DATA), .PIX_VALID(PIX_VALID),
    .PIX_READY(PIX_READY), .PIX_SOF(PIX_SOF), .PIX_EOL(PIX_EOL)
  );

  ov7670_frame_reader #(
    .H_ACT(4), .V_ACT(3), .DATA_W(16), .ADDR_W(17),
    .BASE_ADDR(100), .RD_LAT(1), .FIFO_DEPTH(4)
  ) u_dut1 (
    .SYS_CLK(clk), .RST_N(RST_N), .READ_EN(READ_EN1),
    .RD_FRAME(RD_FRAME1), .BUSY(BUSY1), .MEM_RD(MEM_RD1),
    .MEM_ADDR(MEM_ADDR1), .MEM_RDATA(MEM_RDATA1),
    .PIX_DATA(PIX_DATA1), .PIX_VALID(PIX_VALID1),
    .PIX_READY(PIX_READY1), .PIX_SOF(PIX_SOF1), .PIX_EOL(PIX_EOL1)
  );

  // Memory models: word at address A holds A, returned RD_LAT cycles later.
  logic [16:0] a0_d1 = '0, a0_d2 = '0, a1_d1 = '0;
  logic        v0_d1 = 1'b0, v0_d2 = 1'b0, v1_d1 = 1'b0;
  always @(posedge clk) begin
    a0_d1 <= MEM_ADDR;  v0_d1 <= MEM_RD;
    a0_d2 <= a0_d1;     v0_d2 <= v0_d1;
    a1_d1 <= MEM_ADDR1; v1_d1 <= MEM_RD1;
  end
  assign MEM_RDATA  = v0_d2 ? a0_d2[15:0] : 16'hdead;
  assign MEM_RDATA1 = v1_d1 ? a1_d1[15:0] : 16'hdead;

  int n_chk = 0, n_err = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  exp_t q[$];
  exp_t q1[$];
  int   n_pop = 0, pop_base = 0, n_frame = 0, n_iss = 0;
  int   grant_id = 0, seen_id = 0, iss_idx = 0, g_pops = 0;
  int   max_out = 0, cyc_n = 0, t_first = 0, t_last = 0;
  bit   last_prev = 0, bp_on = 0;
  int   bp_ph = 0;
  int   n_pop1 = 0, iss1 = 0, n_frame1 = 0;

  always @(posedge clk) begin
    #1;
    if (bp_on) begin
      bp_ph = (bp_ph == 2) ? 0 : bp_ph + 1;
      PIX_READY = (bp_ph == 0);
    end else begin
      PIX_READY = 1'b1;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    int   out;
    cyc_n++;
    if (!RST_N) begin
      last_prev = 0;
      iss_idx = 0;
    end else begin
      if (seen_id != grant_id) begin
        seen_id = grant_id;
        iss_idx = 0;
        g_pops = 0;
        max_out = 0;
      end
      if (last_prev || RD_FRAME) check("rd_frame", 32'(RD_FRAME), 32'(last_prev));
      if (RD_FRAME) n_frame++;
      last_prev = 0;
      if (MEM_RD) begin
        check("mem_addr", 32'(MEM_ADDR), iss_idx);
        iss_idx++;
        n_iss++;
      end else if (iss_idx > 0) begin
        check("addr_hold", 32'(MEM_ADDR), iss_idx - 1);
      end
      out = iss_idx - g_pops;
      if (out > max_out) max_out = out;
      if (PIX_VALID && PIX_READY) begin
        if (q.size() == 0) begin
          check("unexp_pix", 32'(PIX_DATA), 32'hffff);
        end else begin
          e = q.pop_front();
          check("pix_data", 32'(PIX_DATA), 32'(e.data));
          check("pix_sof", 32'(PIX_SOF), 32'(e.sof));
          check("pix_eol", 32'(PIX_EOL), 32'(e.eol));
          if (e.idx == 0) t_first = cyc_n;
          if (e.last) begin
            t_last = cyc_n;
            last_prev = 1;
          end
        end
        n_pop++;
        g_pops++;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (RST_N) begin
      if (RD_FRAME1) n_frame1++;
      if (MEM_RD1) begin
        check("mem_addr1", 32'(MEM_ADDR1), 100 + iss1);
        iss1++;
      end
      if (PIX_VALID1 && PIX_READY1) begin
        if (q1.size() == 0) begin
          check("unexp_pix1", 32'(PIX_DATA1), 32'hffff);
        end else begin
          e = q1.pop_front();
          check("pix_data1", 32'(PIX_DATA1), 32'(e.data));
          check("pix_sof1", 32'(PIX_SOF1), 32'(e.sof));
          check("pix_eol1", 32'(PIX_EOL1), 32'(e.eol));
        end
        n_pop1++;
      end
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic exp_t mk(input int i, input int base);
    exp_t e;
    e.data = 16'(base + i);
    e.sof  = (i == 0);
    e.eol  = (i % 4) == 3;
    e.last = (i == 11);
    e.idx  = i;
    return e;
  endfunction

  task automatic start_frame();
    q.delete();
    for (int i = 0; i < 12; i++) q.push_back(mk(i, 0));
    grant_id++;
    pop_base = n_pop;
    READ_EN = 1'b1;
  endtask

  task automatic wait_pops(input int n, input int budget);
    int k = 0;
    while (n_pop - pop_base < n && k < budget) begin
      cyc();
      k++;
    end
    check("pop_count", n_pop - pop_base, n);
  endtask

  task automatic check_idle_outs(input string tag);
    check({tag, "_busy"}, 32'(BUSY), 0);
    check({tag, "_rdf"}, 32'(RD_FRAME), 0);
    check({tag, "_memrd"}, 32'(MEM_RD), 0);
    check({tag, "_addr"}, 32'(MEM_ADDR), 0);
    check({tag, "_valid"}, 32'(PIX_VALID), 0);
    check({tag, "_data"}, 32'(PIX_DATA), 0);
    check({tag, "_sof_eol"}, 32'({PIX_SOF, PIX_EOL}), 0);
  endtask

  initial begin
    int k, iss_snap;
    #2;
    check_idle_outs("rst");
    #10;
    RST_N = 1'b1;
    cyc();

    // Full frame, no backpressure, latency RD_LAT+1.
    start_frame();
    cyc();
    check("busy_fetch", 32'(BUSY), 1);
    k = 0;
    while (!PIX_VALID && k < 20) begin
      cyc();
      k++;
    end
    check("latency", k, 3);
    wait_pops(12, 60);
    check("burst_span", t_last - t_first, 11);
    cyc();
    cyc();
    check("frames_1", n_frame, 1);
    check("busy_after", 32'(BUSY), 0);

    // READ_EN held high must not retrigger.
    iss_snap = n_iss;
    repeat (8) cyc();
    check("no_retrig_busy", 32'(BUSY), 0);
    check("no_retrig_iss", n_iss, iss_snap);

    // Rearm with backpressure 1,0,0 pattern.
    READ_EN = 1'b0;
    cyc();
    bp_on = 1;
    start_frame();
    wait_pops(12, 200);
    check("max_outstanding", 32'(max_out <= 4), 1);
    check("bp_used_credit", 32'(max_out >= 3), 1);
    bp_on = 0;
    cyc();
    cyc();
    check("frames_2", n_frame, 2);

    // Abort after 5 pixels.
    READ_EN = 1'b0;
    cyc();
    start_frame();
    wait_pops(5, 60);
    READ_EN = 1'b0;
    cyc();
    check("abort_busy", 32'(BUSY), 0);
    check("abort_valid", 32'(PIX_VALID), 0);
    q.delete();
    repeat (6) cyc();
    check("abort_no_rdf", n_frame, 2);
    start_frame();
    wait_pops(12, 60);
    cyc();
    cyc();
    check("frames_3", n_frame, 3);

    // Asynchronous reset while draining.
    READ_EN = 1'b0;
    cyc();
    start_frame();
    wait_pops(10, 60);
    check("drain_busy", 32'(BUSY), 1);
    #2;
    RST_N = 1'b0;
    READ_EN = 1'b0;
    #1;
    check_idle_outs("arst");
    q.delete();
    @(posedge clk);
    #3;
    RST_N = 1'b1;
    cyc();
    start_frame();
    wait_pops(12, 60);
    cyc();
    cyc();
    check("frames_4", n_frame, 4);

    // Non-zero base, RD_LAT=1.
    for (int i = 0; i < 12; i++) q1.push_back(mk(i, 100));
    READ_EN1 = 1'b1;
    cyc();
    check("busy1_fetch", 32'(BUSY1), 1);
    k = 0;
    while (!PIX_VALID1 && k < 20) begin
      cyc();
      k++;
    end
    check("latency1", k, 2);
    k = 0;
    while (n_pop1 < 12 && k < 60) begin
      cyc();
      k++;
    end
    check("pop_count1", n_pop1, 12);
    cyc();
    cyc();
    check("frames1", n_frame1, 1);
    check("issues1", iss1, 12);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

endmodule
